// File: rtl/wrr_merger_pkg.sv
// Shared types and elaboration helpers for the weighted round-robin FIFO merger.
package wrr_merger_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

  // Legal configuration: 2..16 channels and a tag wide enough to name each one.
  function automatic bit tag_width_ok(input int channels, input int tag_width);
    return (channels >= 2) && (channels <= 16) && (tag_width >= clog2(channels));
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first-set: returns the first requesting channel after ptr_i, wrapping.
module rr_priority_pick
  import wrr_merger_pkg::*;
#(
  parameter int CHANNELS  = 10,
  parameter int TAG_WIDTH = 4
) (
  input  logic [CHANNELS-1:0]  req_i,
  input  logic [TAG_WIDTH-1:0] ptr_i,
  output logic [TAG_WIDTH-1:0] idx_o,
  output logic                 found_o
);

  int   best_s;
  int   dist_s;
  logic hit_s;

  // Pick the requester with the smallest rotational distance from ptr_i.
  always_comb begin
    best_s  = CHANNELS;
    dist_s  = 0;
    hit_s   = 1'b0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      dist_s  = (c > int'(ptr_i)) ? (c - int'(ptr_i) - 32'sd1)
                                  : (c - int'(ptr_i) - 32'sd1 + CHANNELS);
      hit_s   = req_i[c] && (dist_s < best_s);
      best_s  = hit_s ? dist_s : best_s;
      idx_o   = hit_s ? TAG_WIDTH'(c) : idx_o;
      found_o = found_o | hit_s;
    end
  end

endmodule

// File: rtl/wrr_fifo_merger.sv
// Weighted round-robin merger of FWFT source FIFOs into one registered valid/ready stream.
// Optional macro WRR_CHANNEL_TAG_EN places the channel tag in the top bits of DATA_OUT.
module wrr_fifo_merger
  import wrr_merger_pkg::*;
#(
  parameter int CHANNELS     = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                             BUS_CLK,
  input  logic                             BUS_RST,
  input  logic [CHANNELS-1:0]              WRITE_REQ,
  input  logic [CHANNELS-1:0]              HOLD_REQ,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   DATA_IN,
  input  logic [CHANNELS*WEIGHT_WIDTH-1:0] WEIGHT,
  output logic [CHANNELS-1:0]              READ_GRANT,
  input  logic                             READY_OUT,
  output logic                             WRITE_OUT,
  output logic [DATA_WIDTH-1:0]            DATA_OUT,
  output logic [TAG_WIDTH-1:0]             ACTIVE_CH
);

  if (!tag_width_ok(CHANNELS, TAG_WIDTH)) begin : g_bad_cfg
    $error("wrr_fifo_merger: CHANNELS must be 2..16 and TAG_WIDTH >= clog2(CHANNELS)");
  end

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    ptr_q, ptr_d;
  logic [TAG_WIDTH-1:0]    cur_q, cur_d;
  logic [WEIGHT_WIDTH-1:0] quota_q, quota_d;
  logic                    wout_q, wout_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic [TAG_WIDTH-1:0]    pick_idx_s;
  logic                    pick_found_s;
  logic                    req_cur_s;
  logic                    hold_cur_s;
  logic [DATA_WIDTH-1:0]   din_cur_s;
  logic [WEIGHT_WIDTH-1:0] wt_pick_s;
  logic [WEIGHT_WIDTH-1:0] quota_dec_s;
  logic [DATA_WIDTH-1:0]   load_word_s;
  logic                    load_en_s;
  logic                    grant_s;

  rr_priority_pick #(
    .CHANNELS  (CHANNELS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .req_i   (WRITE_REQ),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Per-channel muxes for the served channel and the channel being selected.
  always_comb begin
    req_cur_s  = 1'b0;
    hold_cur_s = 1'b0;
    din_cur_s  = '0;
    wt_pick_s  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      req_cur_s  = (cur_q == TAG_WIDTH'(c)) ? WRITE_REQ[c] : req_cur_s;
      hold_cur_s = (cur_q == TAG_WIDTH'(c)) ? HOLD_REQ[c] : hold_cur_s;
      din_cur_s  = (cur_q == TAG_WIDTH'(c)) ? DATA_IN[c*DATA_WIDTH +: DATA_WIDTH] : din_cur_s;
      wt_pick_s  = (pick_idx_s == TAG_WIDTH'(c)) ? WEIGHT[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                                                 : wt_pick_s;
    end
  end

  assign load_en_s   = !wout_q | READY_OUT;
  assign grant_s     = (state_q == SERVE) & req_cur_s & load_en_s;
  assign quota_dec_s = (quota_q == '0) ? '0 : (quota_q - WEIGHT_WIDTH'(1'b1));

`ifdef WRR_CHANNEL_TAG_EN
  assign load_word_s = {cur_q, din_cur_s[DATA_WIDTH-TAG_WIDTH-1:0]};
`else
  assign load_word_s = din_cur_s;
`endif

  // Pop strobe is combinational so the source sees it in the cycle its word is taken.
  always_comb begin
    READ_GRANT = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      READ_GRANT[c] = grant_s & (cur_q == TAG_WIDTH'(c));
    end
  end

  // Channel selection, quota accounting and burst/packet exit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    quota_d = quota_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = SERVE;
          cur_d   = pick_idx_s;
          quota_d = (wt_pick_s == '0) ? WEIGHT_WIDTH'(1'b1) : wt_pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        quota_d = grant_s ? quota_dec_s : quota_q;
        if (!hold_cur_s && ((grant_s && (quota_dec_s == '0)) || !req_cur_s)) begin
          state_d = IDLE;
          ptr_d   = cur_q;
        end else begin
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry output register: load on grant, drain when consumed without reload.
  always_comb begin
    if (grant_s) begin
      wout_d = 1'b1;
      dout_d = load_word_s;
    end else if (READY_OUT) begin
      wout_d = 1'b0;
      dout_d = dout_q;
    end else begin
      wout_d = wout_q;
      dout_d = dout_q;
    end
  end

  // State registers; ptr resets to the last channel so channel 0 wins first.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      ptr_q   <= TAG_WIDTH'(CHANNELS - 1);
      cur_q   <= '0;
      quota_q <= '0;
      wout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      quota_q <= quota_d;
      wout_q  <= wout_d;
      dout_q  <= dout_d;
    end
  end

  assign WRITE_OUT = wout_q;
  assign DATA_OUT  = dout_q;
  assign ACTIVE_CH = cur_q;

endmodule

// File: doc/wrr_fifo_merger.md
# wrr_fifo_merger

Weighted round-robin merger that drains up to CHANNELS first-word-fall-through source FIFOs (RX channels, timestamp, counter) into a single valid/ready stream for the BRAM output FIFO. It is the parametrised successor of the fixed-width round-robin arbiter in the readout core. It adds:
- a per-channel burst quota (weight);
- packet-hold semantics that keep a grant across empty cycles;
- a registered output stage with back-pressure.

It sits between the per-channel FIFOs and `bram_fifo`, in the BUS_CLK domain.

## Interface
- CHANNELS, 10: number of source channels (2..16).
- DATA_WIDTH, 32: word width.
- WEIGHT_WIDTH, 4: width of each per-channel quota.
- TAG_WIDTH, 4: channel-tag width; must be ≥ clog2(CHANNELS).

Ports:
- BUS_CLK  in  1: the block's single clock.
- BUS_RST  in  1: asynchronous, active-high reset.
- WRITE_REQ  in  CHANNELS: source c has a valid word on DATA_IN (FIFO not empty).
- HOLD_REQ  in  CHANNELS: source c is mid-packet; keep its grant.
- DATA_IN  in  CHANNELS*DATA_WIDTH: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- WEIGHT  in  CHANNELS*WEIGHT_WIDTH: quota per channel, static configuration; a value of 0 is treated as 1.
- READ_GRANT  out  CHANNELS: one-hot pop strobe to source c.
- READY_OUT  in  1: downstream accepts a word this cycle.
- WRITE_OUT  out  1: DATA_OUT is valid.
- DATA_OUT  out  DATA_WIDTH: merged word.
- ACTIVE_CH  out  TAG_WIDTH: channel currently served (valid in SERVE).

## Operation
- States: IDLE and SERVE. Registers: `ptr` (last served channel), `cur`, `quota` (WEIGHT_WIDTH bits), a one-entry output register.
- load_en = !WRITE_OUT | READY_OUT.
- IDLE:
  - If any WRITE_REQ is set, pick the first requesting channel searching from ptr+1 upward, wrapping at CHANNELS.
  - Set cur = that channel and quota = max(WEIGHT[cur], 1), then go to SERVE.
  - No grant is issued in the selection cycle.
- SERVE, grant rule:
  - READ_GRANT[cur] = WRITE_REQ[cur] & load_en, combinational. All other grant bits are 0.
  - On a grant, DATA_IN[cur] is captured into the output register, WRITE_OUT is set, and quota decrements.
- SERVE, exit to IDLE with ptr = cur when either condition holds at the clock edge:
  - quota reaches 0 after this grant and HOLD_REQ[cur] = 0;
  - WRITE_REQ[cur] = 0 and HOLD_REQ[cur] = 0.
- SERVE, hold behaviour:
  - While HOLD_REQ[cur] = 1, stay in SERVE even if quota is 0 or WRITE_REQ[cur] is 0. Words are granted as they arrive.
  - quota saturates at 0 and does not wrap.
- Output register:
  - Cleared (WRITE_OUT = 0) when READY_OUT = 1 and no new grant occurs.
  - Simultaneous consume and load in one cycle gives full throughput.
- Boundary conditions:
  - Output full and READY_OUT = 0: no grant; the source keeps its word.
  - All channels requesting: strictly rotating order by ptr.
  - A channel holding indefinitely starves the others. This is by design; sources must bound packet length.
  - Stale quota: WEIGHT changes are sampled only at selection.

## Timing
- Reset values: WRITE_OUT = 0, DATA_OUT = 0, READ_GRANT = 0, ACTIVE_CH = 0, state = IDLE, ptr = CHANNELS-1 (channel 0 is served first).
- Reset mid-operation clears the output register. A word already popped from its source is lost.
- Latency:
  - Request to first grant: 1 cycle (the selection cycle).
  - Grant to WRITE_OUT: 1 cycle.
- Channel switch overhead: 1 idle cycle per switch.
- Steady-state throughput within a burst: 1 word/cycle while READY_OUT = 1.

## Configuration
- `WRR_CHANNEL_TAG_EN` defined:
  - DATA_OUT[DATA_WIDTH-1 -: TAG_WIDTH] = cur.
  - The lower DATA_WIDTH-TAG_WIDTH bits come from DATA_IN[cur].
- Not defined: DATA_OUT = DATA_IN[cur] unmodified. The tag is available only on ACTIVE_CH.

## Structure
- Package `wrr_merger_pkg`: state enum {IDLE, SERVE}, a clog2 function, and the TAG_WIDTH legality check.
- One sub-module, `rr_priority_pick`: combinational rotate/find-first-set. Takes request vector and ptr; returns index and found flag.

## Test plan
- Reset, then WRITE_REQ = 0: WRITE_OUT stays 0 and no READ_GRANT is issued for 100 cycles.
- CHANNELS = 4, all WEIGHT = 2, all channels always requesting, READY_OUT = 1:
  - service order is ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3,ch0,…;
  - one bubble appears per switch.
- Ch1 with HOLD_REQ = 1 and WRITE_REQ toggling 1,0,0,1, quota 1:
  - grant stays on ch1 and both ch1 words are output;
  - ch2 is served only after HOLD_REQ drops.
- READY_OUT held at 0 for 5 cycles with a word pending:
  - WRITE_OUT stays 1 and DATA_OUT is stable;
  - READ_GRANT = 0 throughout;
  - on release, the word is accepted and the next grant follows in the same cycle.
- Tag macro on, DATA_WIDTH = 32, ch5 sends 0x0000_1234: DATA_OUT = 0x5000_1234.
- BUS_RST asserted in SERVE mid-burst: outputs go to 0 immediately, and channel 0 is served first after release.
